// File: rtl/rw_mem_arbiter.sv
// Two-requester arbiter for the 96x8 synchronous RW data memory.
// Sequences one memory access per grant and returns done/err/data.
module rw_mem_arbiter #(
    parameter logic [7:0] BASE_ADDR  = 8'd128,
    parameter logic [7:0] LIMIT_ADDR = 8'd223,
    parameter bit         FIXED_PRIO = 1'b0,
    parameter logic [7:0] PARK_ADDR  = 8'd0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cpu_req,
    input  logic       cpu_write,
    input  logic [7:0] cpu_address,
    input  logic [7:0] cpu_data_in,
    output logic [7:0] cpu_data_out,
    output logic       cpu_done,
    output logic       cpu_err,
    input  logic       dma_req,
    input  logic       dma_write,
    input  logic [7:0] dma_address,
    input  logic [7:0] dma_data_in,
    output logic [7:0] dma_data_out,
    output logic       dma_done,
    output logic       dma_err,
    output logic       mem_write,
    output logic [7:0] mem_address,
    output logic [7:0] mem_data_in,
    input  logic [7:0] mem_data_out,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    state_t     state;
    logic       owner;
    logic       last_served;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       cmd_err;

    logic       any_req;
    logic       pick_dma;
    logic       sel_write;
    logic [7:0] sel_addr;
    logic [7:0] sel_data;
    logic       sel_err;
    logic       rd_ok;

    // DMA wins only when alone, or on a round-robin tie the CPU took last
    always_comb begin
        any_req   = cpu_req | dma_req;
        pick_dma  = dma_req & (~cpu_req |
                    (~FIXED_PRIO & (last_served == OWN_CPU)));
        sel_write = pick_dma ? dma_write   : cpu_write;
        sel_addr  = pick_dma ? dma_address : cpu_address;
        sel_data  = pick_dma ? dma_data_in : cpu_data_in;
        sel_err   = (sel_addr < BASE_ADDR) | (sel_addr > LIMIT_ADDR);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            owner       <= OWN_CPU;
            last_served <= OWN_DMA;
            cmd_write   <= 1'b0;
            cmd_addr    <= 8'h00;
            cmd_data    <= 8'h00;
            cmd_err     <= 1'b0;
            cpu_done    <= 1'b0;
            cpu_err     <= 1'b0;
            dma_done    <= 1'b0;
            dma_err     <= 1'b0;
        end else begin
            cpu_done <= 1'b0;
            cpu_err  <= 1'b0;
            dma_done <= 1'b0;
            dma_err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        owner       <= pick_dma;
                        last_served <= pick_dma;
                        cmd_write   <= sel_write;
                        cmd_addr    <= sel_addr;
                        cmd_data    <= sel_data;
                        cmd_err     <= sel_err;
                        if (sel_err) begin
                            state    <= RESP;
                            cpu_done <= ~pick_dma;
                            cpu_err  <= ~pick_dma;
                            dma_done <= pick_dma;
                            dma_err  <= pick_dma;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    state    <= RESP;
                    cpu_done <= (owner == OWN_CPU);
                    dma_done <= (owner == OWN_DMA);
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory pins stay parked outside ISSUE so data_out keeps the last read
    always_comb begin
        busy        = (state != IDLE);
        mem_write   = (state == ISSUE) & cmd_write;
        mem_address = (state == ISSUE) ? cmd_addr : PARK_ADDR;
        mem_data_in = (state == ISSUE) ? cmd_data : 8'h00;
        rd_ok       = ~cmd_write & ~cmd_err;
        cpu_data_out = (cpu_done & rd_ok) ? mem_data_out : 8'h00;
        dma_data_out = (dma_done & rd_ok) ? mem_data_out : 8'h00;
    end

endmodule

// File: tb/tb_rw_mem_arbiter.sv
// Directed bench for rw_mem_arbiter: two instances (round-robin and
// fixed priority), each with a behavioural 96x8 synchronous memory.
module tb_rw_mem_arbiter;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic       c_req = 0, c_wr = 0, d_req = 0, d_wr = 0;
    logic [7:0] c_addr = 0, c_din = 0, d_addr = 0, d_din = 0;
    logic [7:0] c_dout, d_dout, m_addr, m_din, m_dout;
    logic       c_done, c_err, d_done, d_err, m_we, busy0;

    logic       pc_req = 0, pd_req = 0;
    logic [7:0] pc_addr = 8'h80, pd_addr = 8'h81;
    logic [7:0] pc_dout, pd_dout, pm_addr, pm_din, pm_dout;
    logic       pc_done, pc_err, pd_done, pd_err, pm_we, busy1;

    int checks = 0;
    int errors = 0;

    rw_mem_arbiter #(.FIXED_PRIO(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(c_req), .cpu_write(c_wr), .cpu_address(c_addr),
        .cpu_data_in(c_din), .cpu_data_out(c_dout),
        .cpu_done(c_done), .cpu_err(c_err),
        .dma_req(d_req), .dma_write(d_wr), .dma_address(d_addr),
        .dma_data_in(d_din), .dma_data_out(d_dout),
        .dma_done(d_done), .dma_err(d_err),
        .mem_write(m_we), .mem_address(m_addr),
        .mem_data_in(m_din), .mem_data_out(m_dout), .busy(busy0)
    );

    rw_mem_arbiter #(.FIXED_PRIO(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(pc_req), .cpu_write(1'b0), .cpu_address(pc_addr),
        .cpu_data_in(8'h00), .cpu_data_out(pc_dout),
        .cpu_done(pc_done), .cpu_err(pc_err),
        .dma_req(pd_req), .dma_write(1'b0), .dma_address(pd_addr),
        .dma_data_in(8'h00), .dma_data_out(pd_dout),
        .dma_done(pd_done), .dma_err(pd_err),
        .mem_write(pm_we), .mem_address(pm_addr),
        .mem_data_in(pm_din), .mem_data_out(pm_dout), .busy(busy1)
    );

    logic [7:0] mem0 [0:95];
    logic [7:0] mem1 [0:95];

    initial begin
        for (int i = 0; i < 96; i++) begin
            mem0[i] = 8'h00;
            mem1[i] = 8'h00;
        end
        m_dout  = 8'h00;
        pm_dout = 8'h00;
    end

    always @(posedge clk) begin
        if (m_addr >= 8'd128 && m_addr <= 8'd223) begin
            if (m_we) mem0[m_addr - 8'd128] <= m_din;
            else      m_dout <= mem0[m_addr - 8'd128];
        end
        if (pm_addr >= 8'd128 && pm_addr <= 8'd223) begin
            if (pm_we) mem1[pm_addr - 8'd128] <= pm_din;
            else       pm_dout <= mem1[pm_addr - 8'd128];
        end
    end

    task automatic run_txn(input bit dma, input bit w,
                           input logic [7:0] a, input logic [7:0] d,
                           output int lat, output logic [7:0] rd,
                           output logic er, output int wrs,
                           output int other);
        lat = -1; rd = 8'hxx; er = 1'bx; wrs = 0; other = 0;
        if (dma) begin
            d_req = 1; d_wr = w; d_addr = a; d_din = d;
        end else begin
            c_req = 1; c_wr = w; c_addr = a; c_din = d;
        end
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (m_we) wrs++;
            if (dma ? c_done : d_done) other++;
            if (dma ? d_done : c_done) begin
                lat = i;
                rd  = dma ? d_dout : c_dout;
                er  = dma ? d_err : c_err;
                break;
            end
        end
        c_req = 0;
        d_req = 0;
        @(negedge clk);
    endtask

    task automatic tie(input logic [7:0] ca, input logic [7:0] da,
                       output int ct, output int dt,
                       output logic [7:0] cr, output logic [7:0] dr);
        ct = -1; dt = -1; cr = 8'hxx; dr = 8'hxx;
        c_req = 1; c_wr = 0; c_addr = ca;
        d_req = 1; d_wr = 0; d_addr = da;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (c_done) begin ct = i; cr = c_dout; c_req = 0; end
            if (d_done) begin dt = i; dr = d_dout; d_req = 0; end
            if (!c_req && !d_req) break;
        end
        c_req = 0;
        d_req = 0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 0;
        repeat (2) @(negedge clk);
        reset_n = 1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 0;
        @(negedge clk);
        checks++;
        if ({c_done, c_err, d_done, d_err, m_we, busy0} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 000000",
                     {c_done, c_err, d_done, d_err, m_we, busy0});
        end
        checks++;
        if ({m_addr, m_din, c_dout, d_dout} !== 32'h0) begin
            errors++;
            $display("FAIL reset_buses got %h want 00000000",
                     {m_addr, m_din, c_dout, d_dout});
        end
        reset_n = 1;
        @(negedge clk);
    endtask

    task automatic test_cpu_rw();
        int lat, wrs, oth;
        logic [7:0] rd;
        logic er;
        run_txn(0, 1, 8'h80, 8'h5A, lat, rd, er, wrs, oth);
        checks++;
        if ({lat, wrs, er, rd} !== {32'd2, 32'd1, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL cpu_wr lat %0d wrs %0d err %b data %h want 2 1 0 00",
                     lat, wrs, er, rd);
        end
        run_txn(0, 0, 8'h80, 8'h00, lat, rd, er, wrs, oth);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL cpu_rd_lat got %0d want 2", lat);
        end
        checks++;
        if ({er, rd, wrs} !== {1'b0, 8'h5A, 32'd0}) begin
            errors++;
            $display("FAIL cpu_rd err %b data %h wrs %0d want 0 5a 0",
                     er, rd, wrs);
        end
    endtask

    task automatic test_dma_bounds();
        int lat, wrs, oth;
        logic [7:0] rd;
        logic er;
        run_txn(1, 1, 8'hDF, 8'h3C, lat, rd, er, wrs, oth);
        checks++;
        if ({lat, wrs, er} !== {32'd2, 32'd1, 1'b0}) begin
            errors++;
            $display("FAIL dma_wr lat %0d wrs %0d err %b want 2 1 0",
                     lat, wrs, er);
        end
        run_txn(1, 0, 8'hDF, 8'h00, lat, rd, er, wrs, oth);
        checks++;
        if ({lat, rd, er, oth} !== {32'd2, 8'h3C, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL dma_rd lat %0d data %h err %b cpu_done %0d want 2 3c 0 0",
                     lat, rd, er, oth);
        end
        run_txn(1, 0, 8'hE0, 8'h00, lat, rd, er, wrs, oth);
        checks++;
        if ({lat, rd, er, wrs} !== {32'd1, 8'h00, 1'b1, 32'd0}) begin
            errors++;
            $display("FAIL dma_e0 lat %0d data %h err %b wrs %0d want 1 00 1 0",
                     lat, rd, er, wrs);
        end
        run_txn(0, 1, 8'hE0, 8'h11, lat, rd, er, wrs, oth);
        checks++;
        if ({lat, er, wrs} !== {32'd1, 1'b1, 32'd0}) begin
            errors++;
            $display("FAIL cpu_wr_e0 lat %0d err %b wrs %0d want 1 1 0",
                     lat, er, wrs);
        end
    endtask

    task automatic test_round_robin();
        int ct, dt, lat, wrs, oth;
        logic [7:0] cr, dr, rd;
        logic er;
        do_reset();
        tie(8'h80, 8'hDF, ct, dt, cr, dr);
        checks++;
        if ({ct, dt} !== {32'd2, 32'd5}) begin
            errors++;
            $display("FAIL rr_first cpu %0d dma %0d want 2 5", ct, dt);
        end
        checks++;
        if ({cr, dr} !== {8'h5A, 8'h3C}) begin
            errors++;
            $display("FAIL rr_data cpu %h dma %h want 5a 3c", cr, dr);
        end
        run_txn(0, 0, 8'h81, 8'h00, lat, rd, er, wrs, oth);
        tie(8'h80, 8'hDF, ct, dt, cr, dr);
        checks++;
        if ({ct, dt} !== {32'd5, 32'd2}) begin
            errors++;
            $display("FAIL rr_alt cpu %0d dma %0d want 5 2", ct, dt);
        end
    endtask

    task automatic test_fixed_prio();
        int cdone[$];
        int ddone;
        bit early;
        ddone = -1;
        early = 0;
        pc_req = 1;
        pd_req = 1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (pc_done) begin
                cdone.push_back(i);
                if (cdone.size() == 4) pc_req = 0;
            end
            if (pd_done) begin
                if (cdone.size() < 4) early = 1;
                ddone = i;
                pd_req = 0;
                break;
            end
        end
        pc_req = 0;
        pd_req = 0;
        @(negedge clk);
        checks++;
        if (cdone.size() != 4 || early) begin
            errors++;
            $display("FAIL fp_cpu_count got %0d early_dma %b want 4 0",
                     cdone.size(), early);
        end else begin
            checks++;
            if ({cdone[0], cdone[1], cdone[2], cdone[3]} !==
                {32'd2, 32'd5, 32'd8, 32'd11}) begin
                errors++;
                $display("FAIL fp_cpu_times got %0d %0d %0d %0d want 2 5 8 11",
                         cdone[0], cdone[1], cdone[2], cdone[3]);
            end
        end
        checks++;
        if (ddone !== 14) begin
            errors++;
            $display("FAIL fp_dma_time got %0d want 14", ddone);
        end
    endtask

    task automatic test_reset_mid_issue();
        int lat, wrs, oth, seen;
        logic [7:0] rd;
        logic er;
        seen = 0;
        c_req = 1; c_wr = 1; c_addr = 8'h90; c_din = 8'h77;
        @(negedge clk);
        checks++;
        if ({m_we, m_addr} !== {1'b1, 8'h90}) begin
            errors++;
            $display("FAIL rst_issue we %b addr %h want 1 90", m_we, m_addr);
        end
        #1 reset_n = 0;
        #1;
        checks++;
        if ({m_we, m_addr, m_din, busy0, c_done} !== 19'h0) begin
            errors++;
            $display("FAIL rst_async we %b addr %h din %h busy %b done %b want 0",
                     m_we, m_addr, m_din, busy0, c_done);
        end
        c_req = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (c_done) seen++;
            if (i == 1) reset_n = 1;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL rst_no_done got %0d want 0", seen);
        end
        run_txn(0, 0, 8'h90, 8'h00, lat, rd, er, wrs, oth);
        checks++;
        if ({lat, rd, er} !== {32'd2, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL rst_reread lat %0d data %h err %b want 2 00 0",
                     lat, rd, er);
        end
    endtask

    task automatic test_err_hold();
        int lat, wrs, oth;
        logic [7:0] rd;
        logic er;
        run_txn(0, 0, 8'h80, 8'h00, lat, rd, er, wrs, oth);
        checks++;
        if ({lat, rd} !== {32'd2, 8'h5A}) begin
            errors++;
            $display("FAIL eh_pre lat %0d data %h want 2 5a", lat, rd);
        end
        run_txn(0, 0, 8'h7F, 8'h00, lat, rd, er, wrs, oth);
        checks++;
        if ({lat, rd, er, m_dout} !== {32'd1, 8'h00, 1'b1, 8'h5A}) begin
            errors++;
            $display("FAIL eh_7f lat %0d data %h err %b mem %h want 1 00 1 5a",
                     lat, rd, er, m_dout);
        end
        run_txn(1, 0, 8'h00, 8'h00, lat, rd, er, wrs, oth);
        checks++;
        if ({lat, rd, er, m_dout} !== {32'd1, 8'h00, 1'b1, 8'h5A}) begin
            errors++;
            $display("FAIL eh_00 lat %0d data %h err %b mem %h want 1 00 1 5a",
                     lat, rd, er, m_dout);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_rw();
        test_dma_bounds();
        test_round_robin();
        test_fixed_prio();
        test_reset_mid_issue();
        test_err_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
